// File: rtl/mmc1_pkg.sv
// Shared constants and types for the MMC1 configuration sequencer.
package mmc1_pkg;

  localparam logic [1:0] MMC1_REG_CTRL = 2'b00;
  localparam logic [1:0] MMC1_REG_CHR0 = 2'b01;
  localparam logic [1:0] MMC1_REG_CHR1 = 2'b10;
  localparam logic [1:0] MMC1_REG_PRG  = 2'b11;

  localparam int MMC1_LOAD_BITS = 5;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_ALIGN = 2'd1,
    ST_WRITE      = 2'd2,
    ST_GAP        = 2'd3
  } seq_state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mmc1_m2_phase_gen.sv
// Free-running phase counter producing the CPU M2 clock and per-period strobes.
module mmc1_m2_phase_gen
  import mmc1_pkg::*;
#(
  parameter int M2_LOW_CYC  = 2,
  parameter int M2_HIGH_CYC = 2,
  parameter int PH_W        = cnt_width(M2_LOW_CYC + M2_HIGH_CYC)
) (
  input  logic            CLK,
  input  logic            nRST,
  output logic [PH_W-1:0] o_ph,
  output logic            o_m2,
  output logic            o_m2_rise,
  output logic            o_period_end
);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(M2_LOW_CYC + M2_HIGH_CYC - 1);
  localparam logic [PH_W-1:0] PH_HIGH = PH_W'(M2_LOW_CYC);
  localparam logic [PH_W-1:0] PH_PRE  = PH_W'(M2_LOW_CYC - 1);

  logic [PH_W-1:0] r_ph;
  logic            r_m2;
  logic [PH_W-1:0] w_ph_next;

  // Strobes describe the edge about to happen, so consumers react in step with M2.
  assign o_period_end = (r_ph == PH_LAST);
  assign o_m2_rise    = (r_ph == PH_PRE);
  assign w_ph_next    = o_period_end ? '0 : r_ph + 1'b1;
  assign o_ph         = r_ph;
  assign o_m2         = r_m2;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ph <= '0;
      r_m2 <= 1'b0;
    end else begin
      r_ph <= w_ph_next;
      r_m2 <= (w_ph_next >= PH_HIGH);
    end
  end

endmodule

// File: rtl/mmc1_cfg_sequencer.sv
// Turns a (register, 5-bit value) or reset request into MMC1 serial CPU write cycles.
//   state       | meaning
//   ST_IDLE     | bus idle, req_ready high once the previous done has retired
//   ST_WAIT_ALIGN | request latched, waiting for the next M2 period start
//   ST_WRITE    | one M2 period with nCPU_RW low, ROMSEL low in the late high phase
//   ST_GAP      | one idle M2 period between serial bits
module mmc1_cfg_sequencer
  import mmc1_pkg::*;
#(
  parameter int M2_LOW_CYC  = 2,
  parameter int M2_HIGH_CYC = 2,
  parameter int ROMSEL_DLY  = 1
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rst,
  input  logic [1:0] req_reg,
  input  logic [4:0] req_data,
  output logic       done,
  output logic       busy,
  output logic       CPU_M2,
  output logic       nCPU_ROMSEL,
  output logic       nCPU_RW,
  output logic       CPU_A13,
  output logic       CPU_A14,
  output logic       CPU_D0,
  output logic       CPU_D7
);

  localparam int PH_W = cnt_width(M2_LOW_CYC + M2_HIGH_CYC);
  localparam int RS_W = cnt_width(ROMSEL_DLY + 1);
  localparam logic [RS_W-1:0] RS_LOAD  = RS_W'(ROMSEL_DLY);
  localparam logic [2:0]      LAST_BIT = 3'(MMC1_LOAD_BITS - 1);

  logic [PH_W-1:0] w_ph_unused;
  logic            w_m2_rise;
  logic            w_period_end;

  seq_state_t      r_state;
  logic            r_ready, r_busy, r_done;
  logic            r_rst_req;
  logic [1:0]      r_reg;
  logic [4:0]      r_data;
  logic [2:0]      r_bit;
  logic [RS_W-1:0] r_rs_cnt;
  logic            r_romsel, r_rw, r_a13, r_a14, r_d0, r_d7;

  mmc1_m2_phase_gen #(
    .M2_LOW_CYC  (M2_LOW_CYC),
    .M2_HIGH_CYC (M2_HIGH_CYC),
    .PH_W        (PH_W)
  ) u_phase (
    .CLK          (CLK),
    .nRST         (nRST),
    .o_ph         (w_ph_unused),
    .o_m2         (CPU_M2),
    .o_m2_rise    (w_m2_rise),
    .o_period_end (w_period_end)
  );

  assign req_ready   = r_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign nCPU_ROMSEL = r_romsel;
  assign nCPU_RW     = r_rw;
  assign CPU_A13     = r_a13;
  assign CPU_A14     = r_a14;
  assign CPU_D0      = r_d0;
  assign CPU_D7      = r_d7;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= ST_IDLE;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rst_req <= 1'b0;
      r_reg     <= '0;
      r_data    <= '0;
      r_bit     <= '0;
      r_rs_cnt  <= '0;
      r_romsel  <= 1'b1;
      r_rw      <= 1'b1;
      r_a13     <= 1'b0;
      r_a14     <= 1'b0;
      r_d0      <= 1'b0;
      r_d7      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // r_ready stays low for one cycle after done, so busy and ready never overlap.
          if (r_ready && req_valid) begin
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_rst_req <= req_rst;
            r_reg     <= req_reg;
            r_data    <= req_data;
            r_bit     <= '0;
            r_state   <= ST_WAIT_ALIGN;
          end else begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        ST_WAIT_ALIGN: begin
          if (w_period_end) begin
            r_state <= ST_WRITE;
            r_rw    <= 1'b0;
            if (r_rst_req) begin
              {r_a14, r_a13} <= MMC1_REG_CTRL;
              r_d0           <= 1'b0;
              r_d7           <= 1'b1;
            end else begin
              {r_a14, r_a13} <= r_reg;
              r_d0           <= r_data[0];
              r_d7           <= 1'b0;
            end
          end
        end
        ST_WRITE: begin
          if (w_period_end) begin
            r_romsel <= 1'b1;
            r_rs_cnt <= '0;
            r_rw     <= 1'b1;
            r_d0     <= 1'b0;
            r_d7     <= 1'b0;
            if (r_rst_req || r_bit == LAST_BIT) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_state <= ST_GAP;
            end
          end else if (w_m2_rise) begin
            r_rs_cnt <= RS_LOAD;
          end else if (r_rs_cnt != '0) begin
            r_rs_cnt <= r_rs_cnt - 1'b1;
            if (r_rs_cnt == RS_W'(1)) r_romsel <= 1'b0;
          end
        end
        ST_GAP: begin
          if (w_period_end) begin
            r_state <= ST_WRITE;
            r_rw    <= 1'b0;
            r_d0    <= r_data[r_bit];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmc1_cfg_sequencer.sv
// Directed bench: drives requests, watches the CPU bus and loads a small MMC1 mapper model.
module tb_mmc1_cfg_sequencer;
  import mmc1_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic       req_valid, req_rst, req_ready, done, busy;
  logic [1:0] req_reg;
  logic [4:0] req_data;
  logic       CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A13, CPU_A14, CPU_D0, CPU_D7;

  logic       req_valid_b, req_rst_b, req_ready_b, done_b, busy_b;
  logic [1:0] req_reg_b;
  logic [4:0] req_data_b;
  logic       m2_b, romsel_b, rw_b, a13_b, a14_b, d0_b, d7_b;

  mmc1_cfg_sequencer u_dut (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ready(req_ready),
    .req_rst(req_rst), .req_reg(req_reg), .req_data(req_data), .done(done), .busy(busy),
    .CPU_M2(CPU_M2), .nCPU_ROMSEL(nCPU_ROMSEL), .nCPU_RW(nCPU_RW), .CPU_A13(CPU_A13),
    .CPU_A14(CPU_A14), .CPU_D0(CPU_D0), .CPU_D7(CPU_D7));

  mmc1_cfg_sequencer #(.M2_LOW_CYC(3), .M2_HIGH_CYC(3), .ROMSEL_DLY(2)) u_dut_b (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_rst(req_rst_b), .req_reg(req_reg_b), .req_data(req_data_b), .done(done_b), .busy(busy_b),
    .CPU_M2(m2_b), .nCPU_ROMSEL(romsel_b), .nCPU_RW(rw_b), .CPU_A13(a13_b),
    .CPU_A14(a14_b), .CPU_D0(d0_b), .CPU_D7(d7_b));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge CLK) cyc++;

  // Bus monitor and MMC1 mapper model for the default-parameter instance.
  int         n_wr = 0, n_done = 0, done_cyc = 0;
  int         wr_start [64];
  int         wr_rs [64];
  logic       wr_d0 [64];
  logic       wr_d7 [64];
  logic [1:0] wr_a [64];
  logic       prev_rw = 1'b1, captured = 1'b0;
  logic [4:0] m_sh = '0;
  int         m_cnt = 0;
  logic [4:0] m_reg [4] = '{5'b01100, 5'b0, 5'b0, 5'b0};

  always @(negedge CLK) begin
    if (nCPU_RW == 1'b0 && prev_rw == 1'b1) begin
      wr_start[n_wr] = cyc;
      wr_rs[n_wr] = 0;
      captured = 1'b0;
      n_wr++;
    end
    if (nCPU_ROMSEL == 1'b0 && n_wr > 0) wr_rs[n_wr-1]++;
    if (nCPU_ROMSEL == 1'b0 && nCPU_RW == 1'b0 && !captured && n_wr > 0) begin
      captured = 1'b1;
      wr_d0[n_wr-1] = CPU_D0;
      wr_d7[n_wr-1] = CPU_D7;
      wr_a[n_wr-1]  = {CPU_A14, CPU_A13};
      if (CPU_D7) begin
        m_sh = '0;
        m_cnt = 0;
        m_reg[0] = m_reg[0] | 5'b01100;
      end else begin
        m_sh = {CPU_D0, m_sh[4:1]};
        m_cnt++;
        if (m_cnt == 5) begin
          m_reg[{CPU_A14, CPU_A13}] = m_sh;
          m_sh = '0;
          m_cnt = 0;
        end
      end
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    prev_rw = nCPU_RW;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic send(input logic r, input logic [1:0] rg, input logic [4:0] d, input string tag);
    int d0;
    d0 = n_done;
    for (int i = 0; i < 50 && !req_ready; i++) step();
    req_valid = 1'b1; req_rst = r; req_reg = rg; req_data = d;
    for (int i = 0; i < 50 && req_ready; i++) step();
    req_valid = 1'b0; req_rst = 1'b0;
    for (int i = 0; i < 400 && n_done == d0; i++) step();
    chk({tag, "_done_seen"}, n_done - d0, 1);
  endtask

  int base, dbase, r1, r2, diff;
  logic pm;
  logic [4:0] bits;
  logic d7_any, a_any;
  int t_ws, t_mr, t_rf, t_rr, t_mf, t_d, nw_b;
  logic p_rw, p_m2, p_rs;

  initial begin
    req_valid = 0; req_rst = 0; req_reg = '0; req_data = '0;
    req_valid_b = 0; req_rst_b = 0; req_reg_b = '0; req_data_b = '0;
    nRST = 1'b0;
    repeat (5) step();
    chk("rst_m2", CPU_M2, 0);
    chk("rst_romsel", nCPU_ROMSEL, 1);
    chk("rst_rw", nCPU_RW, 1);
    chk("rst_a", {CPU_A14, CPU_A13}, 0);
    chk("rst_d", {CPU_D7, CPU_D0}, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    nRST = 1'b1;
    step();
    chk("ready_after_release", req_ready, 1);

    r1 = -1; r2 = -1; pm = CPU_M2;
    for (int i = 0; i < 12; i++) begin
      step();
      if (CPU_M2 && !pm) begin
        if (r1 < 0) r1 = cyc; else if (r2 < 0) r2 = cyc;
      end
      pm = CPU_M2;
    end
    chk("m2_period", r2 - r1, 4);

    // Control register write 01110
    base = n_wr;
    send(1'b0, MMC1_REG_CTRL, 5'b01110, "ctrl");
    chk("ctrl_nwr", n_wr - base, 5);
    bits = '0; d7_any = 0; a_any = 0;
    for (int i = 0; i < 5; i++) begin
      bits[i] = wr_d0[base+i];
      d7_any |= wr_d7[base+i];
      a_any |= |wr_a[base+i];
    end
    chk("ctrl_d0_seq", bits, 5'b01110);
    chk("ctrl_d7", d7_any, 0);
    chk("ctrl_addr", a_any, 0);
    for (int i = 1; i < 5; i++) chk("ctrl_spacing", wr_start[base+i] - wr_start[base+i-1], 8);
    chk("ctrl_latency", done_cyc - wr_start[base], 36);
    chk("ctrl_model", m_reg[0], 5'b01110);

    // Mapper reset write
    base = n_wr;
    send(1'b1, 2'b11, 5'b11111, "rstw");
    repeat (20) step();
    chk("rstw_nwr", n_wr - base, 1);
    chk("rstw_d7", wr_d7[base], 1);
    chk("rstw_d0", wr_d0[base], 0);
    chk("rstw_addr", wr_a[base], 0);
    chk("rstw_romsel_low", wr_rs[base], 1);
    chk("rstw_latency", done_cyc - wr_start[base], 4);
    chk("rstw_model_ctrl", m_reg[0], 5'b01110);
    chk("rstw_model_cnt", m_cnt, 0);

    // Back-to-back PRG then CHR0 with req_valid held
    base = n_wr; dbase = n_done;
    for (int i = 0; i < 50 && !req_ready; i++) step();
    req_valid = 1; req_rst = 0; req_reg = MMC1_REG_PRG; req_data = 5'b00011;
    for (int i = 0; i < 50 && req_ready; i++) step();
    req_reg = MMC1_REG_CHR0; req_data = 5'b10101;
    for (int i = 0; i < 400 && n_done == dbase; i++) step();
    for (int i = 0; i < 50 && !req_ready; i++) step();
    for (int i = 0; i < 50 && req_ready; i++) step();
    req_valid = 0;
    for (int i = 0; i < 400 && n_done < dbase + 2; i++) step();
    chk("b2b_done_count", n_done - dbase, 2);
    chk("b2b_nwr", n_wr - base, 10);
    diff = wr_start[base+5] - wr_start[base+4];
    chk("b2b_idle_gap", diff >= 8, 1);
    chk("b2b_model_prg", m_reg[3], 5'b00011);
    chk("b2b_model_chr0", m_reg[1], 5'b10101);

    // Async reset during the third serial bit
    base = n_wr;
    for (int i = 0; i < 50 && !req_ready; i++) step();
    req_valid = 1; req_reg = MMC1_REG_CHR1; req_data = 5'b11111;
    for (int i = 0; i < 50 && req_ready; i++) step();
    req_valid = 0;
    for (int i = 0; i < 100 && !(n_wr == base + 3 && nCPU_ROMSEL == 1'b0); i++) step();
    chk("midrst_reached_bit3", (n_wr == base + 3) && (nCPU_ROMSEL == 1'b0), 1);
    #1 nRST = 1'b0;
    #1;
    chk("midrst_romsel", nCPU_ROMSEL, 1);
    chk("midrst_rw", nCPU_RW, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_stale_bits", m_cnt, 3);
    repeat (3) step();
    nRST = 1'b1;
    step();
    send(1'b1, 2'b00, 5'b00000, "midrst_rstw");
    send(1'b0, MMC1_REG_CHR1, 5'b01101, "midrst_chr1");
    chk("midrst_model_chr1", m_reg[2], 5'b01101);
    chk("midrst_model_cnt", m_cnt, 0);

    // Alternate timing instance: LOW=3, HIGH=3, ROMSEL_DLY=2
    for (int i = 0; i < 50 && !req_ready_b; i++) step();
    req_valid_b = 1; req_reg_b = MMC1_REG_CHR1; req_data_b = 5'b10110;
    t_ws = -1; t_mr = -1; t_rf = -1; t_rr = -1; t_mf = -1; t_d = -1; nw_b = 0;
    p_rw = rw_b; p_m2 = m2_b; p_rs = romsel_b;
    for (int i = 0; i < 300 && t_d < 0; i++) begin
      step();
      if (!req_ready_b) req_valid_b = 0;
      if (!rw_b && p_rw) begin
        nw_b++;
        if (t_ws < 0) t_ws = cyc;
      end
      if (t_ws >= 0 && m2_b && !p_m2 && t_mr < 0) t_mr = cyc;
      if (t_mr >= 0 && !m2_b && p_m2 && t_mf < 0) t_mf = cyc;
      if (!romsel_b && p_rs && t_rf < 0) t_rf = cyc;
      if (romsel_b && !p_rs && t_rr < 0) t_rr = cyc;
      if (done_b) t_d = cyc;
      p_rw = rw_b; p_m2 = m2_b; p_rs = romsel_b;
    end
    req_valid_b = 0;
    chk("p6_done_seen", t_d >= 0, 1);
    chk("p6_nwr", nw_b, 5);
    chk("p6_romsel_after_m2", t_rf - t_mr, 2);
    chk("p6_romsel_rise_at_m2_fall", t_rr - t_mf, 0);
    chk("p6_latency", t_d - t_ws, 54);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
